// File: rtl/mem_frontdoor_master.sv
// Front-door initiator for a single-port synchronous memory: turns single/burst
// requests into addr/wdata/wr_en/rd_en strobes and returns read beats on a response channel.
module mem_frontdoor_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0]      req_wdata_i,
    input  logic [ADDR_WIDTH-1:0] req_len_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic                  rsp_last_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o,
    input  logic [WIDTH-1:0]      mem_rdata_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the sender holds valid and payload stable until that edge.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_RESP  = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                  rsp_last_q, rsp_last_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  accept;

    // Address wraps at DEPTH-1 even when DEPTH is not a power of two.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign accept = (state_q == IDLE) && req_valid_i && req_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = 1'b0;
        done_d      = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;

        // cnt_q holds the number of beats remaining after the one in flight.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d      = req_len_i;
                    mem_addr_d = req_addr_i;
                    if (req_write_i) begin
                        state_d     = WRITE;
                        mem_wr_en_d = 1'b1;
                        mem_wdata_d = req_wdata_i;
                    end else begin
                        state_d     = RD_ISSUE;
                        mem_rd_en_d = 1'b1;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    req_ready_d = 1'b1;
                end else begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = next_addr(mem_addr_q);
                    mem_wdata_d = mem_wdata_q + WIDTH'(1);
                    cnt_d       = cnt_q - ADDR_WIDTH'(1);
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Memory read data is registered, so it is valid during this cycle.
                state_d     = RD_RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_rdata_i;
                rsp_addr_d  = mem_addr_q;
                rsp_last_d  = (cnt_q == '0);
            end
            RD_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (cnt_q == '0) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d     = RD_ISSUE;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = next_addr(mem_addr_q);
                        cnt_d       = cnt_q - ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_last_o  = rsp_last_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_rd_en_o = mem_rd_en_q;

endmodule

// File: tb/tb_mem_frontdoor_master.sv
// Bench for mem_frontdoor_master: behavioural memory, request driver tasks,
// a negedge monitor popping expected write beats and read responses from queues.
module tb_mem_frontdoor_master;

    localparam int W = 16;
    localparam int D = 64;
    localparam int A = 6;

    logic         clk;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_write_i;
    logic [A-1:0] req_addr_i;
    logic [W-1:0] req_wdata_i;
    logic [A-1:0] req_len_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] rsp_rdata_o;
    logic [A-1:0] rsp_addr_o;
    logic         rsp_last_o;
    logic         done_o;
    logic         busy_o;
    logic [A-1:0] mem_addr_o;
    logic [W-1:0] mem_wdata_o;
    logic         mem_wr_en_o;
    logic         mem_rd_en_o;
    logic [W-1:0] mem_rdata_i;

    mem_frontdoor_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_len_i(req_len_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_addr_o(rsp_addr_o), .rsp_last_o(rsp_last_o), .done_o(done_o), .busy_o(busy_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port memory with registered read data.
    logic [W-1:0] tb_mem [0:D-1];
    always @(posedge clk) begin
        if (mem_wr_en_o) tb_mem[mem_addr_o] <= mem_wdata_o;
        if (mem_rd_en_o) mem_rdata_i <= tb_mem[mem_addr_o];
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]     ref_mem [0:D-1];
    logic [A+W-1:0]   wr_exp_q[$];
    logic [W+A:0]     exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    bit rand_ready = 1'b1;
    bit bp_hold    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Response-ready driver: random, forced high, or held low for back-pressure.
    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold) rsp_ready_i = 1'b0;
            else if (rand_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
            else rsp_ready_i = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [A+W-1:0] we;
        logic [W+A:0]   re;
        logic [W+A:0]   hold_val;
        bit             hold_pend;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                hold_pend = 1'b0;
            end else begin
                if (mem_wr_en_o || mem_rd_en_o)
                    check("strobe_excl", {63'd0, mem_wr_en_o & mem_rd_en_o}, 64'd0);
                if (mem_rd_en_o) rd_cnt++;
                if (done_o) done_cnt++;
                if (mem_wr_en_o) begin
                    check("wr_expected", {63'd0, wr_exp_q.size() > 0}, 64'd1);
                    if (wr_exp_q.size() > 0) begin
                        we = wr_exp_q.pop_front();
                        check("wr_addr", {58'd0, mem_addr_o}, {58'd0, we[A+W-1:W]});
                        check("wr_data", {48'd0, mem_wdata_o}, {48'd0, we[W-1:0]});
                        ref_mem[we[A+W-1:W]] = we[W-1:0];
                    end
                end
                if (hold_pend)
                    check("rsp_hold", {40'd0, rsp_valid_o, rsp_rdata_o, rsp_addr_o, rsp_last_o},
                          {40'd0, 1'b1, hold_val});
                if (rsp_valid_o && rsp_ready_i) begin
                    check("rsp_expected", {63'd0, exp_q.size() > 0}, 64'd1);
                    if (exp_q.size() > 0) begin
                        re = exp_q.pop_front();
                        check("rsp_beat", {41'd0, rsp_rdata_o, rsp_addr_o, rsp_last_o}, {41'd0, re});
                    end
                end
                hold_pend = rsp_valid_o && !rsp_ready_i;
                hold_val  = {rsp_rdata_o, rsp_addr_o, rsp_last_o};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                            input logic [A-1:0] len, output logic acc);
        int n;
        n = 0;
        acc = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_len_i   = len;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready_o;
            n++;
        end
        check("req_accept", {63'd0, acc}, 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom);
        req_addr_i  = A'($urandom);
        req_wdata_i = W'($urandom);
        req_len_i   = A'($urandom);
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic [A-1:0] len);
        int   beats;
        int   run;
        int   done0;
        logic acc;
        beats = int'(len) + 1;
        run   = 0;
        for (int k = 0; k < beats; k++)
            wr_exp_q.push_back({A'((int'(a) + k) % D), W'(int'(d) + k)});
        send_req(1'b1, a, d, len, acc);
        if (!acc) return;
        done0 = done_cnt;
        for (int k = 0; k < beats; k++) begin
            @(negedge clk);
            if (mem_wr_en_o) run++;
        end
        @(negedge clk);
        check("wr_run", run, beats);
        check("wr_end", {60'd0, mem_wr_en_o, done_o, req_ready_o, busy_o}, 64'b0110);
        @(negedge clk);
        check("wr_done_once", done_cnt - done0, 1);
        check("wr_q_empty", wr_exp_q.size(), 0);
    endtask

    task automatic do_read(input logic [A-1:0] a, input logic [A-1:0] len);
        int   beats;
        int   lat;
        int   n;
        int   rd0;
        int   done0;
        logic acc;
        logic got;
        beats = int'(len) + 1;
        for (int k = 0; k < beats; k++)
            exp_q.push_back({ref_mem[(int'(a) + k) % D], A'((int'(a) + k) % D), k == beats - 1});
        rd0 = rd_cnt;
        send_req(1'b0, a, 16'h0, len, acc);
        if (!acc) return;
        done0 = done_cnt;
        lat = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o && lat == 0) lat = i;
        end
        check("rd_latency", lat, 3);
        got = 1'b0;
        n = 0;
        while (!got && n < 2000) begin
            if (done_o) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("rd_done_seen", {63'd0, got}, 64'd1);
        check("rd_done_state", {62'd0, req_ready_o, busy_o}, 64'b10);
        @(negedge clk);
        check("rd_done_once", done_cnt - done0, 1);
        check("rd_pulses", rd_cnt - rd0, beats);
        check("rd_q_empty", exp_q.size(), 0);
    endtask

    task automatic bp_control(input logic [A-1:0] a);
        int  n;
        bit  seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid_o && rsp_ready_i && rsp_addr_o == A'((int'(a) + 1) % D)) seen = 1'b1;
        end
        bp_hold = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid_o) seen = 1'b1;
        end
        check("bp_beat2_seen", {63'd0, seen}, 64'd1);
        repeat (4) @(negedge clk);
        check("bp_addr_held", {58'd0, rsp_addr_o}, {58'd0, A'((int'(a) + 2) % D)});
        bp_hold = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   d0;
        int   n;
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
        acc = 1'b0; d0 = 0; n = 0;
    end

    initial begin
        logic acc;
        int   done0;
        int   n;
        rst_i = 1'b0;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_len_i   = '0;
        for (int i = 0; i < D; i++) ref_mem[i] = '0;

        // Reset with a pending request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {13'd0, req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_addr_o, rsp_last_o,
              done_o, busy_o, mem_addr_o, mem_wdata_o, mem_wr_en_o, mem_rd_en_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {63'd0, req_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("ready_after_edge", {62'd0, req_ready_o, busy_o}, 64'b10);

        // Single write and read back.
        do_write(6'd5, 16'hA5A5, 6'd0);
        do_read(6'd5, 6'd0);

        // Burst crossing the top of the address space.
        do_write(6'd62, 16'h0010, 6'd3);
        do_read(6'd62, 6'd3);

        // Back-pressure on beat 2 of a 4-beat read.
        rand_ready = 1'b0;
        fork
            do_read(6'd62, 6'd3);
            bp_control(6'd62);
        join
        rand_ready = 1'b1;

        // Full-depth fill with data wrapping past 0xFFFF.
        do_write(6'd0, 16'hFFFE, 6'd63);
        do_read(6'd0, 6'd3);

        // Random mix.
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(A'($urandom_range(0, D - 1)), W'($urandom), A'($urandom_range(0, 9)));
            else
                do_read(A'($urandom_range(0, D - 1)), A'($urandom_range(0, 9)));
        end

        // Reset during beat 10 of a 32-beat write.
        for (int k = 0; k < 32; k++)
            wr_exp_q.push_back({A'((20 + k) % D), W'(16'h1234 + k)});
        send_req(1'b1, 6'd20, 16'h1234, 6'd31, acc);
        n = 0;
        while (wr_exp_q.size() > 22 && n < 100) begin
            @(negedge clk);
            n++;
        end
        done0 = done_cnt;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_outputs", {59'd0, mem_wr_en_o, mem_rd_en_o, busy_o, req_ready_o, done_o}, 64'd0);
        check("abort_beats_left", wr_exp_q.size(), 22);
        wr_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - done0, 0);
        check("abort_ready", {63'd0, req_ready_o}, 64'd1);
        do_read(6'd16, 6'd7);
        do_write(6'd30, 16'hBEEF, 6'd1);
        do_read(6'd29, 6'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_frontdoor_master.md
Name: mem_frontdoor_master

Overview:
Front-door initiator for the single-port synchronous memory block (WIDTH x DEPTH, registered read data, write-enable and read-enable strobes).
- Accepts single or burst requests from an upstream valid/ready channel.
- Sequences the memory's addr/wdata/wr_en/rd_en strobes.
- Returns read data on a valid/ready response channel.
Used by the test and config logic to fill, scrub and read back the memory without touching its strobes directly.

Parameters:
WIDTH, 16, data width; equals the memory's WIDTH.
DEPTH, 64, number of memory words; any value from 2 to 2^ADDR_WIDTH.
ADDR_WIDTH, 6, address width; equals the memory's ADDR_WIDTH.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  asynchronous, active-low reset.
req_valid_i  input  1  request valid.
req_ready_o  output  1  request ready; high only in IDLE.
req_write_i  input  1  1 = burst write, 0 = burst read.
req_addr_i  input  ADDR_WIDTH  start address; must be < DEPTH.
req_wdata_i  input  WIDTH  first write data word.
req_len_i  input  ADDR_WIDTH  beat count minus 1.
rsp_valid_o  output  1  read response valid.
rsp_ready_i  input  1  read response ready.
rsp_rdata_o  output  WIDTH  read data.
rsp_addr_o  output  ADDR_WIDTH  address of rsp_rdata_o.
rsp_last_o  output  1  final beat of the burst.
done_o  output  1  one-cycle pulse; request complete.
busy_o  output  1  high in any state other than IDLE.
mem_addr_o  output  ADDR_WIDTH  to memory addr_i.
mem_wdata_o  output  WIDTH  to memory wdata_i.
mem_wr_en_o  output  1  to memory wr_en_i.
mem_rd_en_o  output  1  to memory rd_en_i.
mem_rdata_i  input  WIDTH  from memory rdata_o.

Behaviour:
- All outputs are registered. While rst_i is low, every output is 0 and the state is IDLE.
- req_ready_o first rises on the first clock edge after rst_i goes high.
- Reset asserted mid-operation aborts the burst immediately. Strobes drop asynchronously; no done_o; no response.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE: req_valid_i && req_ready_o at an edge captures write, addr, wdata and len.
  - Write request -> WRITE.
  - Read request -> RD_ISSUE.
  - req_ready_o is 0 from the cycle after acceptance until the return to IDLE.
- Beats = req_len_i + 1, from 1 to 2^ADDR_WIDTH beats.
- Address of beat k = (start + k) mod DEPTH; wraps from DEPTH-1 to 0 for non-power-of-2 DEPTH.
- WRITE: mem_wr_en_o = 1 for exactly `beats` consecutive cycles.
  - Beat k drives mem_addr_o = addr_k and mem_wdata_o = (req_wdata_i + k) mod 2^WIDTH.
  - There is no back-pressure.
  - In the cycle after the last beat: state = IDLE, done_o = 1, req_ready_o = 1.
- RD_ISSUE: mem_rd_en_o = 1 for one cycle with mem_addr_o = addr_k. -> RD_WAIT.
- RD_WAIT: strobes are 0. mem_rdata_i is sampled at the end of this cycle into rsp_rdata_o. -> RD_RESP.
- RD_RESP: rsp_valid_o = 1; rsp_addr_o = addr_k; rsp_last_o = 1 on the final beat only.
  - rsp_rdata_o, rsp_addr_o and rsp_last_o are held stable while rsp_ready_i is low.
  - On handshake, a non-final beat -> RD_ISSUE for beat k+1.
  - On handshake, the final beat -> IDLE, with done_o = 1 in the next cycle.
- Read throughput: 3 cycles per beat minimum. Each extra cycle of rsp_ready_i low adds one cycle.
- mem_wr_en_o and mem_rd_en_o are never high together and are both 0 outside WRITE and RD_ISSUE.
- mem_addr_o and mem_wdata_o hold their last values when idle.
- busy_o = !IDLE.
- A request presented while not ready is ignored; upstream holds it until accepted.
- done_o and req_ready_o are both high in the first IDLE cycle, so a back-to-back request is accepted on that edge.

Test Plan:
- Reset: hold rst_i low for 3 edges with req_valid_i = 1 -> all outputs 0, no strobes. First edge after release -> req_ready_o = 1.
- Single write then read: write addr 5, data 0xA5A5, len 0 -> one wr_en cycle at addr 5. Read addr 5 -> rsp_rdata_o = 0xA5A5, rsp_last_o = 1, rsp_valid_o exactly 3 cycles after acceptance.
- Burst with wrap: DEPTH = 64; write addr 62, len 3, data 0x0010 -> addresses 62,63,0,1 get 0x0010..0x0013. Read back the same burst -> four responses in order, rsp_last_o only on addr 1.
- Back-pressure: 4-beat read with rsp_ready_i low for 5 cycles on beat 2 -> beat 2 data and address stable throughout. No extra rd_en pulses; total responses = 4.
- Full-depth fill: write addr 0, len 63, data 0xFFFE -> 64 consecutive wr_en cycles, data wraps 0xFFFF -> 0x0000 at beat 2. done_o pulses once.
- Mid-burst reset: drop rst_i during beat 10 of a 32-beat write -> strobes drop immediately, no done_o. After release, a new request is accepted normally.
